// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the input debouncer and its sync chain.
package debounce_pkg;

   typedef enum logic {STABLE, CANDIDATE} deb_state_t;

   localparam int unsigned GLITCH_CNT_W = 8;

   function automatic int unsigned cnt_width(int n);
      return 32'($clog2(n + 1));
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer: s is a_async delayed by SYNC_STAGES clock edges.
module sync_chain #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a_async,
   output logic s
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= {SYNC_STAGES{RESET_LEVEL}};
      else     ff <= {ff[SYNC_STAGES-2:0], a_async};
   end

   assign s = ff[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces an async 1-bit input into a clean level with rise/fall pulses.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of rejected glitches.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a_async,
   output logic a_clean,
   output logic rise,
   output logic fall,
   output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

   localparam int unsigned       CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam bit                FAST     = (STABLE_CYCLES == 1);

   logic             s;
   deb_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             clean_next, rise_next, fall_next;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .a_async (a_async),
      .s       (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= STABLE;
         cnt     <= '0;
         a_clean <= RESET_LEVEL;
         rise    <= 1'b0;
         fall    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         a_clean <= clean_next;
         rise    <= rise_next;
         fall    <= fall_next;
         busy    <= (state_next == CANDIDATE);
      end
   end

   // Accept a change once s has differed from a_clean for STABLE_CYCLES samples.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      clean_next = a_clean;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         STABLE: begin
            cnt_next = '0;
            if (s != a_clean) begin
               if (FAST) begin
                  clean_next = ~a_clean;
                  rise_next  = ~a_clean;
                  fall_next  = a_clean;
               end else begin
                  state_next = CANDIDATE;
                  cnt_next   = CNT_W'(1);
               end
            end
         end
         CANDIDATE: begin
            if (s == a_clean) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               clean_next = ~a_clean;
               rise_next  = ~a_clean;
               fall_next  = a_clean;
               state_next = STABLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = STABLE;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   // A candidate that falls back to the clean level is a rejected glitch.
   always_ff @(posedge clk) begin
      if (rst)
         glitch_count <= '0;
      else if (state == CANDIDATE && s == a_clean && glitch_count != '1)
         glitch_count <= glitch_count + GLITCH_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed checks of input_debouncer (STABLE_CYCLES 4 and 1) against a run-length model.
module tb_input_debouncer;

   localparam int unsigned SYNC = 2;
   localparam logic        RL   = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_async = 1'b0;
   logic clean0, rise0, fall0, busy0;
   logic clean1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch0, glitch1;
`endif

   int checks = 0;
   int errors = 0;

   input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .RESET_LEVEL(RL)) dut0 (
      .clk(clk), .rst(rst), .a_async(a_async),
      .a_clean(clean0), .rise(rise0), .fall(fall0), .busy(busy0)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , .glitch_count(glitch0)
`endif
   );

   input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .RESET_LEVEL(RL)) dut1 (
      .clk(clk), .rst(rst), .a_async(a_async),
      .a_clean(clean1), .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , .glitch_count(glitch1)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: delay line of raw samples plus a run length of disagreeing samples.
   bit mq[$];
   bit m_clean[2], m_rise[2], m_fall[2], m_busy[2];
   int m_run[2], m_glitch[2];

   function automatic int need(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic model_step(input bit a, input bit r);
      bit samp;
      if (r) begin
         mq.delete();
         for (int i = 0; i < SYNC; i++) mq.push_back(RL);
         for (int d = 0; d < 2; d++) begin
            m_clean[d] = RL; m_rise[d] = 0; m_fall[d] = 0; m_busy[d] = 0;
            m_run[d] = 0; m_glitch[d] = 0;
         end
      end else begin
         samp = mq.pop_back();
         mq.push_front(a);
         for (int d = 0; d < 2; d++) begin
            m_rise[d] = 0; m_fall[d] = 0;
            if (samp != m_clean[d]) begin
               m_run[d]++;
               if (m_run[d] == need(d)) begin
                  m_rise[d]  = !m_clean[d];
                  m_fall[d]  = m_clean[d];
                  m_clean[d] = !m_clean[d];
                  m_run[d]   = 0;
               end
            end else begin
               if (m_run[d] > 0 && m_glitch[d] < 255) m_glitch[d]++;
               m_run[d] = 0;
            end
            m_busy[d] = (m_run[d] > 0);
         end
      end
   endtask

   task automatic tick(input bit a, input bit r);
      a_async = a;
      rst     = r;
      @(posedge clk);
      #1;
      model_step(a, r);
   endtask

   function automatic logic [3:0] obs(int d);
      return (d == 0) ? {clean0, rise0, fall0, busy0} : {clean1, rise1, fall1, busy1};
   endfunction

   function automatic logic [3:0] expv(int d);
      return {m_clean[d], m_rise[d], m_fall[d], m_busy[d]};
   endfunction

   task automatic test_reset();
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs(d) !== 4'b0000) begin
            errors++;
            $display("FAIL reset dut%0d clean/rise/fall/busy got %b want 0000", d, obs(d));
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch0 !== 8'd0) begin
         errors++;
         $display("FAIL reset_glitch got %0d want 0", glitch0);
      end
`endif
   endtask

   task automatic test_rise();
      int rise_k = 0, rises = 0;
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 1'b0);
         if (rise0) begin rises++; if (rise_k == 0) rise_k = k; end
         checks++;
         if (busy0 !== ((k >= 3 && k <= 5) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rise_busy k=%0d got %b want %b", k, busy0, (k >= 3 && k <= 5));
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL rise_vec k=%0d dut%0d got %b want %b", k, d, obs(d), expv(d));
            end
         end
      end
      checks++;
      if (rise_k !== 6 || rises !== 1) begin
         errors++;
         $display("FAIL rise_latency got edge %0d count %0d want edge 6 count 1", rise_k, rises);
      end
   endtask

   task automatic test_bounce();
      bit seq[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      int g_start = m_glitch[0];
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      g_start = 0;
      for (int k = 0; k < 10; k++) begin
         tick(seq[k], 1'b0);
         checks++;
         if (clean0 !== 1'b0 || rise0 !== 1'b0) begin
            errors++;
            $display("FAIL bounce k=%0d clean=%b rise=%b want 0 0", k, clean0, rise0);
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL bounce_vec k=%0d dut%0d got %b want %b", k, d, obs(d), expv(d));
            end
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch0 !== 8'(g_start + 1)) begin
         errors++;
         $display("FAIL bounce_glitch got %0d want %0d", glitch0, g_start + 1);
      end
`endif
   endtask

   task automatic test_bounce_train();
      bit seq[13] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      int rise_k = 0, rises = 0;
      for (int k = 1; k <= 13; k++) begin
         tick(seq[k-1], 1'b0);
         if (rise0) begin rises++; if (rise_k == 0) rise_k = k; end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL train_vec k=%0d dut%0d got %b want %b", k, d, obs(d), expv(d));
            end
         end
      end
      checks++;
      if (rise_k !== 10 || rises !== 1 || clean0 !== 1'b1) begin
         errors++;
         $display("FAIL train_rise got edge %0d count %0d clean %b want edge 10 count 1 clean 1",
                  rise_k, rises, clean0);
      end
   endtask

   task automatic test_fall();
      int fall_k = 0, falls = 0;
      for (int k = 1; k <= 8; k++) begin
         tick(1'b0, 1'b0);
         if (fall0) begin falls++; if (fall_k == 0) fall_k = k; end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL fall_vec k=%0d dut%0d got %b want %b", k, d, obs(d), expv(d));
            end
         end
      end
      checks++;
      if (fall_k !== 6 || falls !== 1 || clean0 !== 1'b0) begin
         errors++;
         $display("FAIL fall_latency got edge %0d count %0d clean %b want edge 6 count 1 clean 0",
                  fall_k, falls, clean0);
      end
   endtask

   task automatic test_reset_mid();
      int rise_k = 0, rises = 0;
      for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0);
      checks++;
      if (busy0 !== 1'b1 || clean0 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_pre busy=%b clean=%b want 1 0", busy0, clean0);
      end
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs(d) !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_reset dut%0d got %b want 0000", d, obs(d));
         end
      end
      for (int k = 1; k <= 10; k++) begin
         tick(1'b0, 1'b0);
         checks++;
         if (rise0 !== 1'b0 || rise1 !== 1'b0 || obs(0) !== expv(0)) begin
            errors++;
            $display("FAIL midrst_quiet k=%0d rise0=%b rise1=%b vec %b want 0 0 %b",
                     k, rise0, rise1, obs(0), expv(0));
         end
      end
      tick(1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 1'b0);
         if (rise0) begin rises++; if (rise_k == 0) rise_k = k; end
         checks++;
         if (obs(0) !== expv(0)) begin
            errors++;
            $display("FAIL midrst_vec k=%0d got %b want %b", k, obs(0), expv(0));
         end
      end
      checks++;
      if (rise_k !== 6 || rises !== 1) begin
         errors++;
         $display("FAIL midrst_rise got edge %0d count %0d want edge 6 count 1", rise_k, rises);
      end
   endtask

   task automatic test_fast();
      bit seq[7] = '{1, 0, 0, 0, 0, 0, 0};
      tick(1'b0, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         tick(seq[k-1], 1'b0);
         checks++;
         if (clean1 !== (k == 3) || rise1 !== (k == 3) || fall1 !== (k == 4) || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL fast k=%0d clean/rise/fall/busy got %b%b%b%b want %b%b%b0",
                     k, clean1, rise1, fall1, busy1, (k == 3), (k == 3), (k == 4));
         end
      end
   endtask

   task automatic test_random();
      bit a = 1'b0;
      int hold = 0;
      for (int k = 0; k < 800; k++) begin
         if (hold == 0) begin
            a = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
         end
         hold--;
         tick(a, ($urandom_range(0, 99) == 0));
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL random_vec k=%0d dut%0d got %b want %b", k, d, obs(d), expv(d));
            end
         end
         checks++;
         if ((rise0 & fall0) !== 1'b0 || (rise1 & fall1) !== 1'b0) begin
            errors++;
            $display("FAIL random_excl k=%0d rise/fall got %b%b %b%b want no overlap",
                     k, rise0, fall0, rise1, fall1);
         end
`ifdef DEBOUNCE_GLITCH_CNT_EN
         checks++;
         if (glitch0 !== 8'(m_glitch[0])) begin
            errors++;
            $display("FAIL random_glitch k=%0d got %0d want %0d", k, glitch0, m_glitch[0]);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_bounce();
      test_bounce_train();
      test_fall();
      test_reset_mid();
      test_fast();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
